// File: rtl/tcdm_bank_arbiter.sv
// Purpose: shares one TCDM bank port between N_CH requesters (round-robin or fixed priority with starvation override).
// Latency: grant is combinational (0 cycles); the read-valid is routed back to its channel 1 cycle after accept.
// Backpressure: grant-based; when bank_gnt_i=0 nothing is granted and pointer/counters hold.
module tcdm_bank_arbiter #(
  parameter int N_CH     = 4,
  parameter int ID_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int WAIT_W   = 3,
  parameter int MAX_WAIT = 2**WAIT_W - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            TCDM_arb_policy_i,
  input  logic [N_CH-1:0] data_req_i,
  output logic [N_CH-1:0] data_gnt_o,
  output logic            bank_req_o,
  input  logic            bank_gnt_i,
  output logic [ID_W-1:0] gnt_id_o,
  input  logic            bank_rvalid_i,
  output logic [N_CH-1:0] data_r_valid_o,
  output logic            protocol_err_o
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);
  localparam logic [ID_W-1:0]   LAST_CH = ID_W'(N_CH - 1);

  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   r_id_q;
  logic              r_pend_q;
  logic              err_q;
  logic [WAIT_W-1:0] cnt_q [N_CH];

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [ID_W:0]     rr_sum;
  logic [ID_W-1:0]   rr_winner;
  logic              rr_found;
  logic [N_CH-1:0]   starve;
  logic [ID_W-1:0]   st_winner;
  logic              st_any;
  logic [ID_W-1:0]   lo_winner;
  logic [ID_W-1:0]   winner;
  logic              accept;

  // Round-robin: rotate requests so ptr_q sits at bit 0, take the first set bit, map back.
  always_comb begin
    req_dbl   = {data_req_i, data_req_i};
    req_rot   = N_CH'(req_dbl >> ptr_q);
    rr_sum    = '0;
    rr_winner = '0;
    rr_found  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!rr_found && req_rot[i]) begin
        rr_found = 1'b1;
        rr_sum   = {1'b0, ptr_q} + (ID_W+1)'(i);
        if (rr_sum >= (ID_W+1)'(N_CH)) begin
          rr_sum = rr_sum - (ID_W+1)'(N_CH);
        end
        rr_winner = rr_sum[ID_W-1:0];
      end
    end
  end

  // Fixed priority: lowest-index starving requester first, else lowest-index requester.
  always_comb begin
    st_winner = '0;
    st_any    = 1'b0;
    lo_winner = '0;
    for (int k = 0; k < N_CH; k++) begin
      starve[k] = data_req_i[k] && (cnt_q[k] == MAX_CNT);
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (starve[k]) begin
        st_winner = ID_W'(k);
        st_any    = 1'b1;
      end
      if (data_req_i[k]) begin
        lo_winner = ID_W'(k);
      end
    end
  end

  // Winner select, grant fan-out and response routing.
  always_comb begin
    bank_req_o = |data_req_i;
    accept     = bank_req_o & bank_gnt_i;
    if (!bank_req_o) begin
      winner = '0;
    end else if (TCDM_arb_policy_i) begin
      winner = st_any ? st_winner : lo_winner;
    end else begin
      winner = rr_winner;
    end
    gnt_id_o = winner;
    for (int k = 0; k < N_CH; k++) begin
      data_gnt_o[k] = accept && (winner == ID_W'(k));
      // A response arriving while reset is held belongs to a discarded transaction.
      data_r_valid_o[k] = bank_rvalid_i && r_pend_q && !rst && (r_id_q == ID_W'(k));
    end
    protocol_err_o = err_q;
  end

  // Priority pointer advances past the round-robin winner on each accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept && !TCDM_arb_policy_i) begin
      ptr_q <= (winner == LAST_CH) ? '0 : winner + ID_W'(1);
    end
  end

  // Per-channel wait counters, live only in fixed-priority mode.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (rst || !TCDM_arb_policy_i || !data_req_i[k]) begin
        cnt_q[k] <= '0;
      end else if (accept) begin
        if (winner == ID_W'(k)) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] != MAX_CNT) begin
          cnt_q[k] <= cnt_q[k] + WAIT_W'(1);
        end
      end
    end
  end

  // Remember who was accepted so the next-cycle read-valid can be routed; flag stray responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_q   <= '0;
      r_pend_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      r_pend_q <= accept;
      if (accept) begin
        r_id_q <= winner;
      end
      err_q <= bank_rvalid_i & ~r_pend_q;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Purpose: directed table-driven bench for tcdm_bank_arbiter (N_CH=4, MAX_WAIT=3).
// Latency: inputs driven on the falling edge, combinational outputs sampled 1 ns later.
// Backpressure: bank stalls are driven explicitly through bank_gnt_i in the vectors.
module tb_tcdm_bank_arbiter;

  logic       clk;
  logic       rst;
  logic       pol;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       breq;
  logic       bgnt;
  logic [1:0] gid;
  logic       rv;
  logic [3:0] rvo;
  logic       perr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       pol;
    logic [3:0] req;
    logic       bgnt;
    logic       rv;
    logic [3:0] exp_gnt;
    logic       exp_breq;
    logic [1:0] exp_id;
    logic [3:0] exp_rvo;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  tcdm_bank_arbiter #(
    .N_CH(4), .ID_W(2), .WAIT_W(3), .MAX_WAIT(3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .TCDM_arb_policy_i(pol),
    .data_req_i       (req),
    .data_gnt_o       (gnt),
    .bank_req_o       (breq),
    .bank_gnt_i       (bgnt),
    .gnt_id_o         (gid),
    .bank_rvalid_i    (rv),
    .data_r_valid_o   (rvo),
    .protocol_err_o   (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic [3:0] r, input logic g, input logic v,
                     input logic [3:0] eg, input logic eb, input logic [1:0] ei,
                     input logic [3:0] erv, input logic ee);
    vec_t x;
    x.pol = p; x.req = r; x.bgnt = g; x.rv = v;
    x.exp_gnt = eg; x.exp_breq = eb; x.exp_id = ei; x.exp_rvo = erv; x.exp_err = ee;
    vecs.push_back(x);
  endtask

  initial begin
    //   pol req      gnt rv   exp_gnt  breq id  rvo      err
    // idle right after reset
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 4'b0000, 0);
    // round-robin rotation with all channels requesting
    add(0, 4'b1111, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 4'b0100, 1, 2'd2, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 4'b1000, 1, 2'd3, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    // single requester ch3 wraps pointer to 0; stalled probe shows ptr=0
    add(0, 4'b1000, 1, 0, 4'b1000, 1, 2'd3, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 4'b0000, 1, 2'd0, 4'b0000, 0);
    // move pointer to 1, then stall three cycles with req=0110
    add(0, 4'b1111, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(0, 4'b0110, 0, 0, 4'b0000, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0110, 0, 0, 4'b0000, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0110, 0, 0, 4'b0000, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0110, 1, 0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0110, 1, 0, 4'b0100, 1, 2'd2, 4'b0000, 0);
    // fixed priority with starvation override: 0,0,0,2,0,0,0,2
    add(1, 4'b0101, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0100, 1, 2'd2, 4'b0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0100, 1, 2'd2, 4'b0000, 0);
    // back to round-robin: pointer kept at 3 across the fixed phase
    add(0, 4'b1111, 1, 0, 4'b1000, 1, 2'd3, 4'b0000, 0);
    // response routing: accept ch2, then ch1 while ch2's response returns
    add(0, 4'b0100, 1, 0, 4'b0100, 1, 2'd2, 4'b0000, 0);
    add(0, 4'b0010, 1, 1, 4'b0010, 1, 2'd1, 4'b0100, 0);
    add(0, 4'b0000, 1, 1, 4'b0000, 0, 2'd0, 4'b0010, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 4'b0000, 0);

    rst = 1'b1; pol = 1'b0; req = '0; bgnt = 1'b0; rv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      pol = vecs[i].pol; req = vecs[i].req; bgnt = vecs[i].bgnt; rv = vecs[i].rv;
      #1;
      chk($sformatf("v%0d data_gnt", i), 32'(gnt),  32'(vecs[i].exp_gnt));
      chk($sformatf("v%0d bank_req", i), 32'(breq), 32'(vecs[i].exp_breq));
      chk($sformatf("v%0d gnt_id", i),   32'(gid),  32'(vecs[i].exp_id));
      chk($sformatf("v%0d r_valid", i),  32'(rvo),  32'(vecs[i].exp_rvo));
      chk($sformatf("v%0d perr", i),     32'(perr), 32'(vecs[i].exp_err));
      @(negedge clk);
    end

    // Reset while a response is pending: ptr=2 so ch0 wins, then reset with rvalid high.
    pol = 1'b0; req = 4'b0001; bgnt = 1'b1; rv = 1'b0;
    #1;
    chk("rst_seq accept", 32'(gnt), 32'h1);
    @(negedge clk);
    rst = 1'b1; req = '0; rv = 1'b1;
    #1;
    chk("rst_seq r_valid_in_reset", 32'(rvo), 32'h0);
    @(negedge clk);
    // First cycle after release: stray rvalid, nothing routed, error shows next cycle.
    rst = 1'b0; rv = 1'b1;
    #1;
    chk("rst_seq r_valid_after", 32'(rvo), 32'h0);
    chk("rst_seq perr_low", 32'(perr), 32'h0);
    @(negedge clk);
    rv = 1'b0;
    #1;
    chk("rst_seq perr_pulse", 32'(perr), 32'h1);
    @(negedge clk);
    #1;
    chk("rst_seq perr_clear", 32'(perr), 32'h0);

    // Stray rvalid after idle cycles.
    repeat (2) @(negedge clk);
    rv = 1'b1;
    #1;
    chk("stray r_valid", 32'(rvo), 32'h0);
    chk("stray perr_same_cycle", 32'(perr), 32'h0);
    @(negedge clk);
    rv = 1'b0;
    #1;
    chk("stray perr_pulse", 32'(perr), 32'h1);
    @(negedge clk);
    #1;
    chk("stray perr_clear", 32'(perr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Shares one TCDM bank port between N_CH requesters inside the Log-XBar.
- Policy is run-time selectable: round-robin with a rotating priority pointer, or fixed-priority with starvation protection through per-channel wait counters.
- Tracks the ID of each accepted request and routes the bank's read-valid, which returns one cycle later, back to the originating channel.
- Uses grant-based flow control throughout.

Parameters:
- N_CH, 4: number of requesting channels (>=2).
- ID_W, $clog2(N_CH): width of channel index.
- WAIT_W, 3: width of each per-channel wait counter.
- MAX_WAIT, 2**WAIT_W-1: wait count at which a channel is forced to win in fixed mode (1..2**WAIT_W-1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- TCDM_arb_policy_i  in  1  0 = round-robin, 1 = fixed priority (lowest index highest) with starvation override.
- data_req_i  in  N_CH  per-channel request.
- data_gnt_o  out  N_CH  per-channel grant, one-hot or zero.
- bank_req_o  out  1  request to bank.
- bank_gnt_i  in  1  bank accepts this cycle.
- gnt_id_o  out  ID_W  winning channel index; drives the payload mux outside this block.
- bank_rvalid_i  in  1  bank response valid, exactly 1 cycle after an accept.
- data_r_valid_o  out  N_CH  routed response valid, one-hot or zero.
- protocol_err_o  out  1  registered 1-cycle pulse on an unexpected bank_rvalid_i.

Behaviour:
- Reset, applied synchronously while rst=1:
  - prio pointer ptr_q=0, all wait counters=0, r_id_q=0, r_pend_q=0, protocol_err_o=0.
  - Combinational outputs are all 0 when data_req_i=0.
- Request and grant, combinational (0-cycle latency):
  - bank_req_o = |data_req_i.
  - accept = bank_req_o & bank_gnt_i.
  - data_gnt_o[k] = accept & (winner==k).
  - gnt_id_o = winner. When there is no request, winner=0.
- Round-robin (policy=0):
  - Winner is the first requesting channel found scanning from ptr_q upward, wrapping N_CH-1 -> 0.
  - On accept: ptr_q <= winner+1, or 0 if winner==N_CH-1.
  - ptr_q holds when there is no accept, including bank stall (bank_gnt_i=0) with requests pending.
- Fixed (policy=1):
  - A starving channel has cnt[k]==MAX_WAIT. If any requesting channel is starving, the winner is the lowest-index starving one; otherwise the lowest-index requesting one.
  - ptr_q holds.
- Wait counters, updated only in fixed mode; all cleared every cycle while policy=0:
  - If req[k]=0: cnt[k] <= 0.
  - Else if accept and winner==k: cnt[k] <= 0.
  - Else if accept and winner!=k: cnt[k] <= cnt[k]+1, saturating at MAX_WAIT.
  - Else (stall, no accept): hold.
- Policy change takes effect combinationally in the same cycle. ptr_q keeps its value across policy switches.
- Response routing:
  - On accept: r_id_q <= winner, r_pend_q <= 1; otherwise r_pend_q <= 0.
  - data_r_valid_o[k] = bank_rvalid_i & r_pend_q & (r_id_q==k).
  - If bank_rvalid_i=1 and r_pend_q=0: no data_r_valid_o asserted, protocol_err_o=1 next cycle.
- Back-to-back accepts every cycle are supported; the response for the accept at cycle t is routed at t+1 concurrently with a new accept.
- Reset mid-operation: a pending response is discarded (r_pend_q=0). A bank_rvalid_i arriving in the first cycle after reset release raises protocol_err_o.
- Requesters must hold req until granted. The arbiter does not require this, but fairness guarantees assume it.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then all req=0 -> data_gnt_o=0, bank_req_o=0, gnt_id_o=0, protocol_err_o=0.
- RR rotation, N_CH=4, policy=0, req=4'b1111, bank_gnt_i=1 for 6 cycles -> grants to ch 0,1,2,3,0,1. Then req=4'b1000 for one cycle -> grant ch3, ptr_q=0.
- Stall hold, policy=0, req=4'b0110, ptr_q=1, bank_gnt_i=0 for 3 cycles, then 1 -> data_gnt_o=0 during the stall. First grant goes to ch1, next to ch2; ptr_q unchanged during the stall.
- Starvation, policy=1, MAX_WAIT=3, req=4'b0101 constant, bank_gnt_i=1 -> grant sequence ch0,ch0,ch0,ch2,ch0,ch0,ch0,ch2. cnt[2] reads 1,2,3,0 across the sequence.
- Response routing: accepts to ch2 at cycle t and ch1 at t+1, bank_rvalid_i=1 at t+1 and t+2 -> data_r_valid_o=4'b0100 at t+1, 4'b0010 at t+2.
- Protocol error / reset: accept at t, rst=1 at t+1 with bank_rvalid_i=1 -> no data_r_valid_o. Stray bank_rvalid_i with no prior accept -> protocol_err_o pulses exactly one cycle later.
